procesador_fifo0_32_bit_up: RTL and testbench

- Upstream companion to the ST-to-MM download FIFO: the HPS/Nios writes 32-bit words through an Avalon-MM write slave, and the block replays them as an Avalon-ST source into the processing chain.
- Single-clock buffer (2^DEPTH_LOG2 words) with a show-ahead output register honouring source backpressure.
- Includes a status/control register for fill level, overflow and flush.

---
 rtl/procesador_fifo0_32_bit_up.sv | 178 +++++++++++++++++
 tb/tb_procesador_fifo0_32_bit_up.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/procesador_fifo0_32_bit_up.sv
// Avalon-MM write slave feeding an Avalon-ST source through a show-ahead FIFO,
// with a status/control register. Optional almost_empty flag: PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN.
module procesador_fifo0_32_bit_up #(
   parameter int DATA_W       = 32,
   parameter int DEPTH_LOG2   = 11,
   parameter int ALMOST_EMPTY = 16
) (
   input  logic                  wrclock,
   input  logic                  reset_n,
   input  logic                  avalonmm_write_slave_address,
   input  logic                  avalonmm_write_slave_write,
   input  logic [DATA_W-1:0]     avalonmm_write_slave_writedata,
   input  logic                  avalonmm_write_slave_read,
   output logic [31:0]           avalonmm_write_slave_readdata,
   output logic [DATA_W-1:0]     avalonst_source_data,
   output logic                  avalonst_source_valid,
   input  logic                  avalonst_source_ready,
   output logic [DEPTH_LOG2:0]   fifo_level
`ifdef PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN
   ,
   output logic                  almost_empty
`endif
);

   localparam int unsigned            CAPACITY = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]    CAP_LVL  = CAPACITY[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]    LVL_ZERO = {(DEPTH_LOG2+1){1'b0}};
   localparam logic [DEPTH_LOG2:0]    LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0]  PTR_ZERO = {DEPTH_LOG2{1'b0}};
   localparam logic [DEPTH_LOG2-1:0]  PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   // The level field must sit below the flag bits of the status word.
   if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 27 || ALMOST_EMPTY < 0) begin : g_bad_cfg
      $error("procesador_fifo0_32_bit_up: unsupported DEPTH_LOG2/ALMOST_EMPTY");
   end

   logic [DATA_W-1:0]     mem_r [0:CAPACITY-1];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   level_r;
   logic                  valid_r;
   logic [DATA_W-1:0]     data_r;
   logic                  ovf_r;
   logic [31:0]           rdata_r;
   logic                  ae_r;

   logic                  push_s;
   logic                  drop_s;
   logic                  pop_s;
   logic                  flush_s;
   logic                  load_s;
   logic                  stat_rd_s;
   logic [DEPTH_LOG2:0]   level_nxt_s;
   logic [31:0]           status_s;

   // Transfer decode, next level and the status word (all judged on pre-edge state).
   always_comb begin
      push_s      = 1'b0;
      drop_s      = 1'b0;
      pop_s       = valid_r & avalonst_source_ready;
      flush_s     = avalonmm_write_slave_write & avalonmm_write_slave_address
                    & avalonmm_write_slave_writedata[0];
      stat_rd_s   = avalonmm_write_slave_read & avalonmm_write_slave_address;
      level_nxt_s = level_r;
      status_s    = 32'h0000_0000;

      if (avalonmm_write_slave_write && !avalonmm_write_slave_address) begin
         if (level_r != CAP_LVL) begin
            push_s = 1'b1;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
         drop_s = 1'b0;
      end

      // Storage (excluding the output register) is non-empty when level exceeds valid.
      load_s = (!valid_r || pop_s) && (level_r > {{DEPTH_LOG2{1'b0}}, valid_r});

      if (flush_s) begin
         level_nxt_s = LVL_ZERO;
      end else begin
         case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
         endcase
      end

      status_s[DEPTH_LOG2:0] = level_r;
      status_s[29]           = (level_r == CAP_LVL);
      status_s[30]           = (level_r == LVL_ZERO);
      status_s[31]           = ovf_r;
`ifdef PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN
      status_s[28]           = ae_r;
`else
      status_s[28]           = 1'b0;
`endif
   end

   // Storage array write port; contents need no reset.
   always_ff @(posedge wrclock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= avalonmm_write_slave_writedata;
      end
   end

   // Pointers, level, show-ahead output register and sticky overflow.
   always_ff @(posedge wrclock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
         valid_r  <= 1'b0;
         data_r   <= {DATA_W{1'b0}};
         ovf_r    <= 1'b0;
      end else if (flush_s) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
         valid_r  <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         level_r <= level_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (load_s) begin
            data_r   <= mem_r[rd_ptr_r];
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            valid_r  <= 1'b1;
         end else if (pop_s) begin
            valid_r  <= 1'b0;
         end
         // A same-cycle overflow wins over the clear-on-read.
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (stat_rd_s) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Registered read data; holds while no read is issued.
   always_ff @(posedge wrclock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_r <= 32'h0000_0000;
      end else if (avalonmm_write_slave_read) begin
         rdata_r <= stat_rd_s ? status_s : 32'h0000_0000;
      end else begin
         rdata_r <= rdata_r;
      end
   end

`ifdef PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN
   localparam logic [DEPTH_LOG2:0] AE_LVL = ALMOST_EMPTY[DEPTH_LOG2:0];

   // Almost-empty flag tracks the post-edge level.
   always_ff @(posedge wrclock or negedge reset_n) begin
      if (!reset_n) begin
         ae_r <= 1'b1;
      end else begin
         ae_r <= (level_nxt_s <= AE_LVL);
      end
   end

   assign almost_empty = ae_r;
`else
   assign ae_r = 1'b0;
`endif

   assign avalonmm_write_slave_readdata = rdata_r;
   assign avalonst_source_data          = data_r;
   assign avalonst_source_valid         = valid_r;
   assign fifo_level                    = level_r;

endmodule

// File: tb/tb_procesador_fifo0_32_bit_up.sv
// Directed self-checking bench for procesador_fifo0_32_bit_up (default parameters).
module tb_procesador_fifo0_32_bit_up;

   logic        wrclock = 1'b0;
   logic        reset_n;
   logic        address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic [31:0] st_data;
   logic        st_valid;
   logic        st_ready;
   logic [11:0] level;
`ifdef PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN
   logic        almost_empty;
   localparam logic [31:0] AE_BIT = 32'h1000_0000;
`else
   localparam logic [31:0] AE_BIT = 32'h0000_0000;
`endif

   int total = 0;
   int bad   = 0;

   procesador_fifo0_32_bit_up dut (
      .wrclock                        (wrclock),
      .reset_n                        (reset_n),
      .avalonmm_write_slave_address   (address),
      .avalonmm_write_slave_write     (write),
      .avalonmm_write_slave_writedata (writedata),
      .avalonmm_write_slave_read      (read),
      .avalonmm_write_slave_readdata  (readdata),
      .avalonst_source_data           (st_data),
      .avalonst_source_valid          (st_valid),
      .avalonst_source_ready          (st_ready),
      .fifo_level                     (level)
`ifdef PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN
      ,
      .almost_empty                   (almost_empty)
`endif
   );

   always #5 wrclock = ~wrclock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge wrclock);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      write     = 1'b1;
      address   = 1'b0;
      writedata = d;
      tick();
      write     = 1'b0;
   endtask

   task automatic status_read();
      read    = 1'b1;
      address = 1'b1;
      tick();
      read    = 1'b0;
      address = 1'b0;
   endtask

   task automatic flush();
      write     = 1'b1;
      address   = 1'b1;
      writedata = 32'h0000_0001;
      tick();
      write     = 1'b0;
      address   = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      address   = 1'b0;
      write     = 1'b0;
      writedata = 32'h0;
      read      = 1'b0;
      st_ready  = 1'b0;
      repeat (3) tick();
      chk("rst_valid", st_valid, 1'b0);
      chk("rst_level", level, 12'd0);
      chk("rst_rdata", readdata, 32'h0);
      chk("rst_data", st_data, 32'h0);
`ifdef PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN
      chk("rst_ae", almost_empty, 1'b1);
`endif
      reset_n = 1'b1;
      tick();

      // single word, write-to-valid latency and pop
      st_ready = 1'b1;
      push(32'hA5A5_0001);
      chk("lat_valid0", st_valid, 1'b0);
      chk("lat_level1", level, 12'd1);
      tick();
      chk("lat_valid1", st_valid, 1'b1);
      chk("lat_data", st_data, 32'hA5A5_0001);
      tick();
      chk("pop_valid", st_valid, 1'b0);
      chk("pop_level", level, 12'd0);

      // backpressure then burst drain
      st_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(32'(i));
      tick();
      chk("bp_valid", st_valid, 1'b1);
      chk("bp_data", st_data, 32'h1);
      chk("bp_level", level, 12'd4);
      st_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", st_valid, 1'b1);
         chk("drain_data", st_data, 32'(i));
         tick();
      end
      chk("drain_empty", st_valid, 1'b0);
      chk("drain_level", level, 12'd0);
      st_ready = 1'b0;

      // fill to capacity and overflow
      for (int i = 0; i < 2048; i++) push(32'h100 + 32'(i));
      chk("full_level", level, 12'd2048);
      push(32'h0000_DEAD);
      chk("ovf_level", level, 12'd2048);
      status_read();
      chk("stat_ovf", readdata, 32'hA000_0800);
      status_read();
      chk("stat_clr", readdata, 32'h2000_0800);
      chk("full_head", st_data, 32'h100);

      // pop and push together while full: push is still dropped
      st_ready  = 1'b1;
      write     = 1'b1;
      address   = 1'b0;
      writedata = 32'h0000_BEEF;
      tick();
      write     = 1'b0;
      st_ready  = 1'b0;
      chk("pp_level", level, 12'd2047);
      chk("pp_data", st_data, 32'h101);
      status_read();
      chk("pp_stat", readdata, 32'h8000_07FF);
      read    = 1'b1;
      address = 1'b0;
      tick();
      read    = 1'b0;
      chk("rd_addr0", readdata, 32'h0);
      status_read();
      chk("stat_7ff", readdata, 32'h0000_07FF);
      tick();
      chk("rd_hold", readdata, 32'h0000_07FF);

      // flush, refill, flush again
      flush();
      chk("fl_valid", st_valid, 1'b0);
      chk("fl_level", level, 12'd0);
      for (int i = 0; i < 10; i++) push(32'h200 + 32'(i));
      tick();
      chk("ten_level", level, 12'd10);
      chk("ten_head", st_data, 32'h200);
      flush();
      chk("fl2_valid", st_valid, 1'b0);
      chk("fl2_level", level, 12'd0);
      status_read();
      chk("fl2_stat", readdata, 32'h4000_0000 | AE_BIT);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) push(32'h300 + 32'(i));
      tick();
      chk("ar_pre_valid", st_valid, 1'b1);
      @(negedge wrclock);
      reset_n = 1'b0;
      #1;
      chk("ar_valid", st_valid, 1'b0);
      chk("ar_level", level, 12'd0);
      chk("ar_data", st_data, 32'h0);
      tick();
      reset_n = 1'b1;
      tick();

`ifdef PROCESADOR_FIFO_UP_ALMOST_EMPTY_EN
      chk("ae_rst", almost_empty, 1'b1);
      for (int i = 0; i < 16; i++) push(32'(i));
      chk("ae_16", almost_empty, 1'b1);
      push(32'h17);
      chk("ae_17", almost_empty, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
